riscv_mc_control: RTL and testbench

Parametrised multicycle RISC-V control unit for the P2 core: a single FSM plus ALU decode that drives the shared-memory datapath (PC, IR, ALUOut, register file, memory mux). It supersedes the fixed-latency control with a memory ready handshake and full B-type compare set. It also adds a multi-cycle multiply/divide unit (MDU) handshake with watchdog and a sticky illegal-instruction trap.

---
 rtl/riscv_mc_control.sv | 328 ++++++++++++++++++++++++++++++++
 tb/tb_riscv_mc_control.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_mc_control.sv
// riscv_mc_control: multicycle RISC-V control unit for the P2 core.
//
// One FSM plus ALU decode drives the shared-memory datapath (PC, IR, ALUOut,
// register file, memory address mux). Memory accesses wait on mem_ready.
// Multiply/divide instructions use a start/done handshake, and a watchdog
// guards that handshake. Anything undecodable lands in a sticky TRAP state.
//
// Build option: define RVM_EN to route R-type funct7=0000001 into the MDU
// state. Without it that encoding traps and mdu_start is held at 0.
//
// Ports
//   clk, rst            clock (rising edge), async active-low reset
//   en                  advance enable; low freezes state and all write strobes
//   opcode/funct3/funct7 instruction fields from IR
//   mem_ready           memory access completes this cycle
//   zero, lt, ltu       ALU compare flags
//   mdu_done            MDU result valid
//   IorD .. mdu_start   datapath strobes
//   PCSrc, ALUSrcA, ALUSrcB, MemToReg, ALUcontrol  datapath selects
//   Ins_type            immediate format (combinational from opcode/funct3)
//   illegal             sticky trap flag
//   state_dbg           current state encoding
//
// state   | meaning
// FETCH   | read IR from memory at PC, PC <= PC+4 on mem_ready
// DECODE  | ALUOut <= oldPC + imm (branch/JAL target), dispatch on opcode
// MEMADR  | ALUOut <= rs1 + imm
// MEMRD   | load data read, wait mem_ready
// MEMWB   | rd <= memory data
// MEMWR   | store write, held until mem_ready
// EXEC    | R/I-type ALU operation into ALUOut
// ALUWB   | rd <= ALUOut
// BRANCH  | compare rs1/rs2, PC <= ALUOut if taken
// JAL     | PC <= ALUOut, rd <= PC
// JALR    | PC <= (rs1 + imm) & ~1, rd <= PC
// UPPER   | LUI / AUIPC into ALUOut
// MDU     | multiply/divide handshake with watchdog
// TRAP    | illegal instruction, sets sticky flag

module riscv_mc_control #(
  parameter int ALUC_W         = 4,
  parameter int MDU_MAX_CYCLES = 34,
  parameter bit TRAP_HALT      = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic              mem_ready,
  input  logic              zero,
  input  logic              lt,
  input  logic              ltu,
  input  logic              mdu_done,
  output logic              IorD,
  output logic              IRWrite,
  output logic              MemWrite,
  output logic              PCWrite,
  output logic              RegWrite,
  output logic              ALUOutEn,
  output logic              mdu_start,
  output logic [1:0]        PCSrc,
  output logic [1:0]        ALUSrcA,
  output logic [1:0]        ALUSrcB,
  output logic [1:0]        MemToReg,
  output logic [ALUC_W-1:0] ALUcontrol,
  output logic [2:0]        Ins_type,
  output logic              illegal,
  output logic [3:0]        state_dbg
);

`ifdef RVM_EN
  localparam bit MDU_ON = 1'b1;
`else
  localparam bit MDU_ON = 1'b0;
`endif

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JAL    = 4'd9,
    S_JALR   = 4'd10,
    S_UPPER  = 4'd11,
    S_MDU    = 4'd12,
    S_TRAP   = 4'd13
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_SLL   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_SLT   = 4'd8;
  localparam logic [3:0] ALU_SLTU  = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  // Last counter value before the watchdog fires: MDU_MAX_CYCLES cycles in MDU.
  localparam logic [7:0] MDU_LAST = 8'(MDU_MAX_CYCLES - 1);

  state_t     state_q, state_d;
  logic [7:0] mdu_cnt_q, mdu_cnt_d;
  logic       illegal_q, illegal_d;

  logic       iord, ir_wr, mem_wr, pc_wr, reg_wr, aluout_en, mdu_go;
  logic [1:0] pc_src, src_a, src_b, m2r;
  logic [3:0] alu_op, alu_dec;
  logic       act;

  // Strobes are gated by reset as well as en so nothing writes while rst is low.
  assign act = en & rst;

  // funct7[5] selects SUB only for register-register ops; SRA for both.
  always_comb begin
    alu_dec = ALU_ADD;
    case (funct3)
      3'b000:  alu_dec = (opcode == OP_REG && funct7[5]) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_dec = ALU_SLL;
      3'b010:  alu_dec = ALU_SLT;
      3'b011:  alu_dec = ALU_SLTU;
      3'b100:  alu_dec = ALU_XOR;
      3'b101:  alu_dec = funct7[5] ? ALU_SRA : ALU_SRL;
      3'b110:  alu_dec = ALU_OR;
      default: alu_dec = ALU_AND;
    endcase
  end

  always_comb begin
    Ins_type = 3'b000;
    case (opcode)
      OP_IMM:          Ins_type = (funct3 == 3'b001 || funct3 == 3'b101) ? 3'b001 : 3'b000;
      OP_STORE:        Ins_type = 3'b010;
      OP_BR:           Ins_type = 3'b011;
      OP_JAL:          Ins_type = 3'b100;
      OP_LUI, OP_AUIPC: Ins_type = 3'b101;
      OP_REG:          Ins_type = 3'b111;
      default:         Ins_type = 3'b000;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    mdu_cnt_d = mdu_cnt_q;
    iord      = 1'b0;
    ir_wr     = 1'b0;
    mem_wr    = 1'b0;
    pc_wr     = 1'b0;
    reg_wr    = 1'b0;
    aluout_en = 1'b0;
    mdu_go    = 1'b0;
    pc_src    = 2'b00;
    src_a     = 2'b00;
    src_b     = 2'b00;
    m2r       = 2'b00;
    alu_op    = ALU_ADD;

    case (state_q)
      S_FETCH: begin
        src_b = 2'b01;
        ir_wr = mem_ready;
        pc_wr = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        src_a     = 2'b10;
        src_b     = 2'b10;
        aluout_en = 1'b1;
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_REG:            state_d = (funct7 == 7'b0000001) ? (MDU_ON ? S_MDU : S_TRAP) : S_EXEC;
          OP_IMM:            state_d = S_EXEC;
          OP_BR:             state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_LUI, OP_AUIPC:  state_d = S_UPPER;
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        src_a     = 2'b01;
        src_b     = 2'b10;
        aluout_en = 1'b1;
        state_d   = (opcode == OP_STORE) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        reg_wr  = 1'b1;
        m2r     = 2'b01;
        state_d = S_FETCH;
      end
      S_MEMWR: begin
        iord   = 1'b1;
        mem_wr = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXEC: begin
        src_a     = 2'b01;
        src_b     = (opcode == OP_REG) ? 2'b00 : 2'b10;
        alu_op    = alu_dec;
        aluout_en = 1'b1;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_wr  = 1'b1;
        m2r     = 2'b00;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        src_a   = 2'b01;
        src_b   = 2'b00;
        pc_src  = 2'b01;
        state_d = S_FETCH;
        case (funct3)
          3'b000:  begin alu_op = ALU_SUB;  pc_wr = zero; end
          3'b001:  begin alu_op = ALU_SUB;  pc_wr = ~zero; end
          3'b100:  begin alu_op = ALU_SLT;  pc_wr = lt; end
          3'b101:  begin alu_op = ALU_SLT;  pc_wr = ~lt; end
          3'b110:  begin alu_op = ALU_SLTU; pc_wr = ltu; end
          3'b111:  begin alu_op = ALU_SLTU; pc_wr = ~ltu; end
          default: state_d = S_TRAP;
        endcase
      end
      S_JAL: begin
        pc_wr   = 1'b1;
        pc_src  = 2'b01;
        reg_wr  = 1'b1;
        m2r     = 2'b10;
        state_d = S_FETCH;
      end
      S_JALR: begin
        src_a   = 2'b01;
        src_b   = 2'b10;
        pc_src  = 2'b10;
        pc_wr   = 1'b1;
        reg_wr  = 1'b1;
        m2r     = 2'b10;
        state_d = S_FETCH;
      end
      S_UPPER: begin
        src_b     = 2'b10;
        aluout_en = 1'b1;
        if (opcode == OP_LUI) begin
          src_a  = 2'b11;
          alu_op = ALU_PASSB;
        end else begin
          src_a  = 2'b10;
          alu_op = ALU_ADD;
        end
        state_d = S_ALUWB;
      end
      S_MDU: begin
        mdu_go    = (mdu_cnt_q == 8'd0);
        m2r       = 2'b11;
        mdu_cnt_d = mdu_cnt_q + 8'd1;
        // A result arriving on the watchdog's last cycle is still accepted.
        if (mdu_done) begin
          reg_wr    = 1'b1;
          mdu_cnt_d = 8'd0;
          state_d   = S_FETCH;
        end else if (mdu_cnt_q == MDU_LAST) begin
          mdu_cnt_d = 8'd0;
          state_d   = S_TRAP;
        end
      end
      S_TRAP: begin
        if (!TRAP_HALT) state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    if (!en) begin
      state_d   = state_q;
      mdu_cnt_d = mdu_cnt_q;
    end
    illegal_d = illegal_q | (state_d == S_TRAP);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_FETCH;
      mdu_cnt_q <= 8'd0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mdu_cnt_q <= mdu_cnt_d;
      illegal_q <= illegal_d;
    end
  end

  assign IorD       = iord;
  assign IRWrite    = ir_wr & act;
  assign MemWrite   = mem_wr & act;
  assign PCWrite    = pc_wr & act;
  assign RegWrite   = reg_wr & act;
  assign ALUOutEn   = aluout_en & act;
  assign mdu_start  = MDU_ON & mdu_go & act;
  assign PCSrc      = pc_src;
  assign ALUSrcA    = src_a;
  assign ALUSrcB    = src_b;
  assign MemToReg   = m2r;
  assign ALUcontrol = ALUC_W'(alu_op);
  assign illegal    = illegal_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_riscv_mc_control.sv
module tb_riscv_mc_control;

  logic       clk = 1'b0;
  logic       rst, en, mem_ready, zero, lt, ltu, mdu_done;
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic       IorD, IRWrite, MemWrite, PCWrite, RegWrite, ALUOutEn, mdu_start;
  logic [1:0] PCSrc, ALUSrcA, ALUSrcB, MemToReg;
  logic [3:0] ALUcontrol;
  logic [2:0] Ins_type;
  logic       illegal;
  logic [3:0] state_dbg;

  riscv_mc_control dut (
    .clk(clk), .rst(rst), .en(en), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .mem_ready(mem_ready), .zero(zero), .lt(lt), .ltu(ltu), .mdu_done(mdu_done),
    .IorD(IorD), .IRWrite(IRWrite), .MemWrite(MemWrite), .PCWrite(PCWrite),
    .RegWrite(RegWrite), .ALUOutEn(ALUOutEn), .mdu_start(mdu_start),
    .PCSrc(PCSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .MemToReg(MemToReg),
    .ALUcontrol(ALUcontrol), .Ins_type(Ins_type), .illegal(illegal), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  localparam logic [4:0] ST_IR = 5'b10000;
  localparam logic [4:0] ST_MW = 5'b01000;
  localparam logic [4:0] ST_PC = 5'b00100;
  localparam logic [4:0] ST_RW = 5'b00010;
  localparam logic [4:0] ST_MS = 5'b00001;

  typedef struct {
    string       tag;
    logic [16:0] v;
    logic [16:0] m;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Expected strobe event: state, {IRWrite,MemWrite,PCWrite,RegWrite,mdu_start},
  // PCSrc, MemToReg, ALUcontrol; unused selects are masked out.
  function automatic void push(input string tag, input logic [3:0] st, input logic [4:0] stb,
                               input logic [1:0] pcs, input logic [1:0] m2r, input logic [3:0] alu,
                               input bit use_pcs, input bit use_m2r, input bit use_alu);
    exp_t e;
    e.tag = tag;
    e.v   = {st, stb, pcs, m2r, alu};
    e.m   = {4'hf, 5'h1f, use_pcs ? 2'b11 : 2'b00, use_m2r ? 2'b11 : 2'b00, use_alu ? 4'hf : 4'h0};
    sb_q.push_back(e);
  endfunction

  // Every cycle with a write strobe pops one expected event.
  always @(negedge clk) begin
    logic [16:0] obs;
    exp_t e;
    obs = {state_dbg, IRWrite, MemWrite, PCWrite, RegWrite, mdu_start, PCSrc, MemToReg, ALUcontrol};
    if (rst === 1'b1 && (IRWrite | MemWrite | PCWrite | RegWrite | mdu_start)) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_strobe", {15'd0, obs}, 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk(e.tag, {15'd0, obs & e.m}, {15'd0, e.v & e.m});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Fetch (one-cycle memory) and decode; ends in the state after DECODE.
  task automatic fetch_dec(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    chk("fetch_state", state_dbg, 0);
    opcode    = op;
    funct3    = f3;
    funct7    = f7;
    mem_ready = 1'b1;
    push("fetch", 4'd0, ST_IR | ST_PC, 2'b00, 2'b00, 4'd0, 1, 0, 1);
    step();
    mem_ready = 1'b0;
    chk("decode_state", state_dbg, 1);
    chk("decode_aluouten", ALUOutEn, 1);
    step();
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_state", state_dbg, 0);
    chk("rst_illegal", illegal, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  logic [2:0] br_f3   [6] = '{3'b101, 3'b101, 3'b000, 3'b001, 3'b110, 3'b111};
  logic       br_zero [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
  logic       br_lt   [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  logic       br_ltu  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  logic       br_take [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [3:0] br_alu  [6] = '{4'd8, 4'd8, 4'd1, 4'd1, 4'd9, 4'd9};

  logic [6:0] ex_op  [7] = '{7'b0110011, 7'b0010011, 7'b0010011, 7'b0110011, 7'b0110011, 7'b0110011, 7'b0010011};
  logic [2:0] ex_f3  [7] = '{3'b000, 3'b101, 3'b000, 3'b011, 3'b111, 3'b101, 3'b100};
  logic [6:0] ex_f7  [7] = '{7'b0100000, 7'b0100000, 7'b0100000, 7'b0, 7'b0, 7'b0, 7'b0};
  logic [3:0] ex_alu [7] = '{4'd1, 4'd7, 4'd0, 4'd9, 4'd2, 4'd6, 4'd4};
  logic [2:0] ex_ins [7] = '{3'b111, 3'b001, 3'b000, 3'b111, 3'b111, 3'b111, 3'b000};
  logic [1:0] ex_b   [7] = '{2'b00, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b10};

  initial begin
    rst = 1'b0; en = 1'b1; mem_ready = 1'b1; zero = 1'b0; lt = 1'b0; ltu = 1'b0;
    mdu_done = 1'b0; opcode = 7'b0; funct3 = 3'b0; funct7 = 7'b0;

    // reset holds FETCH with strobes low even with mem_ready high
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", state_dbg, 0);
    chk("reset_illegal", illegal, 0);
    chk("reset_irwrite", IRWrite, 0);
    chk("reset_pcwrite", PCWrite, 0);
    mem_ready = 1'b0;
    rst = 1'b1;
    step();

    // lw with three wait cycles in MEMRD
    fetch_dec(7'b0000011, 3'b010, 7'b0);
    chk("lw_memadr", state_dbg, 2);
    chk("lw_memadr_aluouten", ALUOutEn, 1);
    step();
    for (int i = 0; i < 4; i++) begin
      chk("lw_memrd_state", state_dbg, 3);
      chk("lw_memrd_iord", IorD, 1);
      mem_ready = (i == 3);
      step();
    end
    mem_ready = 1'b0;
    chk("lw_memwb_state", state_dbg, 4);
    push("lw_wb", 4'd4, ST_RW, 2'b00, 2'b01, 4'd0, 0, 1, 0);
    step();
    chk("lw_done_state", state_dbg, 0);

    // sw interrupted by reset while MemWrite is high
    fetch_dec(7'b0100011, 3'b010, 7'b0);
    chk("sw_memadr", state_dbg, 2);
    step();
    chk("sw_memwr_state", state_dbg, 5);
    chk("sw_memwrite", MemWrite, 1);
    push("sw_memwr", 4'd5, ST_MW, 2'b00, 2'b00, 4'd0, 0, 0, 0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("midrst_state", state_dbg, 0);
    chk("midrst_memwrite", MemWrite, 0);
    chk("midrst_illegal", illegal, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // branches
    for (int i = 0; i < 6; i++) begin
      zero = br_zero[i]; lt = br_lt[i]; ltu = br_ltu[i];
      fetch_dec(7'b1100011, br_f3[i], 7'b0);
      chk("br_state", state_dbg, 8);
      chk("br_alu", ALUcontrol, br_alu[i]);
      chk("br_instype", Ins_type, 3'b011);
      chk("br_pcwrite", PCWrite, br_take[i]);
      if (br_take[i]) push("br_taken", 4'd8, ST_PC, 2'b01, 2'b00, br_alu[i], 1, 0, 1);
      step();
      zero = 1'b0; lt = 1'b0; ltu = 1'b0;
      chk("br_done_state", state_dbg, 0);
    end

    // R/I ALU ops
    for (int i = 0; i < 7; i++) begin
      fetch_dec(ex_op[i], ex_f3[i], ex_f7[i]);
      chk("ex_state", state_dbg, 6);
      chk("ex_alu", ALUcontrol, ex_alu[i]);
      chk("ex_instype", Ins_type, ex_ins[i]);
      chk("ex_srca", ALUSrcA, 2'b01);
      chk("ex_srcb", ALUSrcB, ex_b[i]);
      step();
      chk("aluwb_state", state_dbg, 7);
      push("aluwb", 4'd7, ST_RW, 2'b00, 2'b00, 4'd0, 0, 1, 0);
      step();
    end

    // en low in FETCH with memory ready
    en = 1'b0;
    mem_ready = 1'b1;
    #1;
    chk("en0_irwrite", IRWrite, 0);
    chk("en0_pcwrite", PCWrite, 0);
    step();
    chk("en0_fetch_hold", state_dbg, 0);
    en = 1'b1;
    mem_ready = 1'b0;

    // en low in EXEC: state and ALUOutEn frozen
    fetch_dec(7'b0110011, 3'b000, 7'b0);
    en = 1'b0;
    #1;
    chk("en0_aluouten", ALUOutEn, 0);
    step();
    chk("en0_exec_hold", state_dbg, 6);
    en = 1'b1;
    #1;
    chk("en1_aluouten", ALUOutEn, 1);
    step();
    push("en_aluwb", 4'd7, ST_RW, 2'b00, 2'b00, 4'd0, 0, 1, 0);
    step();

    // jumps and upper immediates
    fetch_dec(7'b1101111, 3'b000, 7'b0);
    chk("jal_state", state_dbg, 9);
    push("jal", 4'd9, ST_PC | ST_RW, 2'b01, 2'b10, 4'd0, 1, 1, 0);
    step();
    fetch_dec(7'b1100111, 3'b000, 7'b0);
    chk("jalr_state", state_dbg, 10);
    chk("jalr_srca", ALUSrcA, 2'b01);
    chk("jalr_srcb", ALUSrcB, 2'b10);
    push("jalr", 4'd10, ST_PC | ST_RW, 2'b10, 2'b10, 4'd0, 1, 1, 1);
    step();
    fetch_dec(7'b0110111, 3'b000, 7'b0);
    chk("lui_state", state_dbg, 11);
    chk("lui_alu", ALUcontrol, 10);
    chk("lui_srca", ALUSrcA, 2'b11);
    chk("lui_instype", Ins_type, 3'b101);
    step();
    push("lui_wb", 4'd7, ST_RW, 2'b00, 2'b00, 4'd0, 0, 1, 0);
    step();
    fetch_dec(7'b0010111, 3'b000, 7'b0);
    chk("auipc_alu", ALUcontrol, 0);
    chk("auipc_srca", ALUSrcA, 2'b10);
    step();
    push("auipc_wb", 4'd7, ST_RW, 2'b00, 2'b00, 4'd0, 0, 1, 0);
    step();

`ifdef RVM_EN
    // mul completing after 5 cycles
    fetch_dec(7'b0110011, 3'b000, 7'b0000001);
    chk("mdu_state", state_dbg, 12);
    push("mdu_start", 4'd12, ST_MS, 2'b00, 2'b00, 4'd0, 0, 0, 0);
    for (int i = 1; i < 5; i++) begin
      step();
      chk("mdu_wait_state", state_dbg, 12);
      chk("mdu_start_once", mdu_start, 0);
    end
    step();
    mdu_done = 1'b1;
    push("mdu_wb", 4'd12, ST_RW, 2'b00, 2'b11, 4'd0, 0, 1, 0);
    step();
    mdu_done = 1'b0;
    chk("mdu_done_state", state_dbg, 0);

    // mul with no done: watchdog after 34 cycles
    fetch_dec(7'b0110011, 3'b000, 7'b0000001);
    push("mdu_start2", 4'd12, ST_MS, 2'b00, 2'b00, 4'd0, 0, 0, 0);
    for (int i = 1; i < 34; i++) step();
    chk("mdu_last_cycle", state_dbg, 12);
    chk("mdu_last_illegal", illegal, 0);
    step();
    chk("mdu_wdog_state", state_dbg, 13);
    chk("mdu_wdog_illegal", illegal, 1);
    do_reset();
`else
    fetch_dec(7'b0110011, 3'b000, 7'b0000001);
    chk("mul_trap_state", state_dbg, 13);
    chk("mul_trap_illegal", illegal, 1);
    chk("mul_no_start", mdu_start, 0);
    do_reset();
`endif

    // illegal opcode: terminal trap
    fetch_dec(7'b0001111, 3'b000, 7'b0);
    chk("trap_state", state_dbg, 13);
    chk("trap_illegal", illegal, 1);
    mem_ready = 1'b1;
    repeat (100) step();
    chk("trap_hold_state", state_dbg, 13);
    chk("trap_hold_illegal", illegal, 1);
    chk("trap_irwrite", IRWrite, 0);
    mem_ready = 1'b0;
    do_reset();
    chk("post_trap_illegal", illegal, 0);

    step();
    chk("sb_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
